// File: rtl/leaf_rr_scheduler.sv
// Round-robin grant scheduler for the leaf instances of one subtree.
// One registered one-hot tenure at a time, hold limit with block-until-release.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no tenure; pick next eligible leaf round-robin after rr_ptr
// GRANT    | tenure active; hold_cnt = cycles gnt has been high
// COOLDOWN | single dead cycle after release or timeout
module leaf_rr_scheduler #(
  parameter int NUM_REQ  = 5,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = 3,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               timeout,
  output logic [NUM_REQ-1:0] blocked
);

  typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt;
  logic [ID_W-1:0]    rr_ptr, ptr_nxt, id_nxt, winner;
  logic [NUM_REQ-1:0] gnt_nxt, blocked_nxt, eligible;
  logic               timeout_nxt, cur_req, at_limit;

  // First set bit of elig strictly after ptr, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] win;
    logic            found;
    int              sum;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      if (!found && elig[sum[ID_W-1:0]]) begin
        win   = sum[ID_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign eligible = req & ~blocked;
  assign winner   = rr_pick(eligible, rr_ptr);
  assign cur_req  = req[gnt_id];
  assign at_limit = (hold_cnt == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      timeout   <= 1'b0;
      blocked   <= '0;
      hold_cnt  <= '0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= |gnt_nxt;
      gnt_id    <= id_nxt;
      timeout   <= timeout_nxt;
      blocked   <= blocked_nxt;
      hold_cnt  <= hold_nxt;
      rr_ptr    <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (|eligible) state_nxt = GRANT;
      GRANT:    if (!cur_req || at_limit) state_nxt = COOLDOWN;
      COOLDOWN: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt     = '0;
    id_nxt      = '0;
    hold_nxt    = hold_cnt;
    ptr_nxt     = rr_ptr;
    timeout_nxt = 1'b0;
    // A blocked leaf is released the moment it drops its request.
    blocked_nxt = blocked & req;
    case (state)
      IDLE: begin
        if (|eligible) begin
          gnt_nxt  = NUM_REQ'(1) << winner;
          id_nxt   = winner;
          ptr_nxt  = winner;
          hold_nxt = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!cur_req) begin
          hold_nxt = '0;
        end else if (at_limit) begin
          hold_nxt            = '0;
          timeout_nxt         = 1'b1;
          blocked_nxt[gnt_id] = 1'b1;
        end else begin
          gnt_nxt  = gnt;
          id_nxt   = gnt_id;
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        hold_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_leaf_rr_scheduler.sv
// Bench for leaf_rr_scheduler: directed scenarios plus random request traffic,
// every cycle compared against a tenure-level reference model.
module tb_leaf_rr_scheduler;
  localparam int N        = 5;
  localparam int MAX_HOLD = 16;
  localparam int ID_W     = 3;
  localparam int CNT_W    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic          timeout;
  logic [N-1:0]  blocked;

  int total = 0;
  int bad   = 0;

  // Reference model: owner=-1 means no tenure, dead = idle cycles still owed.
  int           m_owner = -1;
  int           m_dead  = 0;
  int           m_ptr   = N - 1;
  int           m_held  = 0;
  logic [N-1:0] m_blk   = '0;
  logic         m_to    = 1'b0;

  leaf_rr_scheduler #(.NUM_REQ(N), .MAX_HOLD(MAX_HOLD), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_valid(gnt_valid),
    .gnt_id(gnt_id), .timeout(timeout), .blocked(blocked)
  );

  always #5 clk = ~clk;

  function automatic logic bit_at(input logic [N-1:0] v, input int i);
    return |(v & (N'(1) << i));
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic rs);
    logic [N-1:0] elig;
    int c;
    if (rs) begin
      m_owner = -1; m_dead = 0; m_ptr = N - 1; m_held = 0; m_blk = '0; m_to = 1'b0;
    end else begin
      elig  = r & ~m_blk;
      m_to  = 1'b0;
      m_blk = m_blk & r;
      if (m_owner >= 0) begin
        if (!bit_at(r, m_owner)) begin
          m_owner = -1; m_dead = 1;
        end else if (m_held == MAX_HOLD) begin
          m_blk   = m_blk | (N'(1) << m_owner);
          m_to    = 1'b1;
          m_owner = -1;
          m_dead  = 1;
        end else begin
          m_held++;
        end
      end else if (m_dead > 0) begin
        m_dead--;
      end else if (elig != '0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (bit_at(elig, c)) begin
            m_owner = c;
            break;
          end
        end
        m_ptr  = m_owner;
        m_held = 1;
      end
    end
  endtask

  task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]    e_gnt;
    logic [ID_W-1:0] e_id;
    e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_id  = (m_owner >= 0) ? ID_W'(m_owner) : '0;
    chk_vec("gnt", gnt, e_gnt);
    chk_int("gnt_valid", int'(gnt_valid), int'(m_owner >= 0));
    chk_int("gnt_id", int'(gnt_id), int'(e_id));
    chk_int("timeout", int'(timeout), int'(m_to));
    chk_vec("blocked", blocked, m_blk);
  endtask

  task automatic step(input logic [N-1:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    step('0, 1'b1);
    step('0, 1'b1);
  endtask

  initial begin
    int n_g, n_to, gap, t_to, t_g4, n_rise2;
    logic prev_v, prev2, rs;
    logic [N-1:0] rq;
    int ord[$];
    int exp_ord[6] = '{0, 1, 2, 3, 4, 0};

    // Reset state
    do_reset();
    chk_vec("reset_gnt", gnt, '0);
    chk_vec("reset_blocked", blocked, '0);

    // Three-cycle request from leaf 0
    n_g = 0; n_to = 0;
    repeat (3) begin
      step(5'b00001, 1'b0);
      if (gnt == 5'b00001) n_g++;
      if (timeout) n_to++;
    end
    repeat (3) begin
      step('0, 1'b0);
      if (gnt != '0) n_g++;
      if (timeout) n_to++;
    end
    chk_int("t1_gnt_cycles", n_g, 3);
    chk_int("t1_timeouts", n_to, 0);

    // All leaves requesting, each releases after two granted cycles
    do_reset();
    rq = 5'b11111; prev_v = 1'b0; gap = 0; ord.delete();
    for (int c = 0; c < 80 && ord.size() < 6; c++) begin
      step(rq, 1'b0);
      if (gnt_valid && !prev_v) begin
        ord.push_back(int'(gnt_id));
        if (ord.size() > 1) chk_int("t2_gap", gap, 2);
        gap = 0;
      end
      if (!gnt_valid) gap++;
      prev_v = gnt_valid;
      rq = 5'b11111;
      if (m_owner >= 0 && m_held == 2) rq = rq & ~(N'(1) << m_owner);
    end
    chk_int("t2_tenures", ord.size(), 6);
    for (int i = 0; i < ord.size() && i < 6; i++) chk_int("t2_order", ord[i], exp_ord[i]);

    // Leaf 2 holds past the limit
    do_reset();
    n_g = 0; n_to = 0;
    for (int c = 0; c < 20; c++) begin
      step(5'b00100, 1'b0);
      if (gnt[2]) n_g++;
      if (timeout) n_to++;
    end
    chk_vec("t3_blocked_held", blocked, 5'b00100);
    step('0, 1'b0);
    chk_vec("t3_blocked_clear", blocked, '0);
    chk_int("t3_gnt_cycles", n_g, 16);
    chk_int("t3_timeouts", n_to, 1);

    // Timeout of leaf 2 with leaf 4 waiting
    do_reset();
    t_to = -1; t_g4 = -1; n_rise2 = 0; prev2 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      step((c < 20) ? 5'b10100 : 5'b00000, 1'b0);
      if (timeout && t_to < 0) t_to = c;
      if (gnt[4] && t_g4 < 0) t_g4 = c;
      if (gnt[2] && !prev2) n_rise2++;
      prev2 = gnt[2];
    end
    chk_int("t4_timeout_at", t_to, 16);
    chk_int("t4_leaf4_delay", t_g4 - t_to, 2);
    chk_int("t4_leaf2_tenures", n_rise2, 1);

    // Reset in the fifth cycle of a tenure, with leaf 3 blocked
    do_reset();
    repeat (17) step(5'b01000, 1'b0);
    chk_vec("t5_blocked_pre", blocked, 5'b01000);
    n_g = 0;
    for (int c = 0; c < 20 && n_g < 5; c++) begin
      step(5'b01010, 1'b0);
      if (gnt == 5'b00010) n_g++;
    end
    chk_int("t5_tenure_cycles", n_g, 5);
    step(5'b01010, 1'b1);
    chk_vec("t5_gnt_after_rst", gnt, '0);
    chk_vec("t5_blocked_after_rst", blocked, '0);
    step(5'b10001, 1'b0);
    chk_vec("t5_first_grant", gnt, 5'b00001);

    // Single-cycle pulse to leaf 3 moves priority to leaf 4
    do_reset();
    step(5'b01000, 1'b0);
    chk_vec("t6_pulse_gnt", gnt, 5'b01000);
    step('0, 1'b0);
    chk_vec("t6_release", gnt, '0);
    step('0, 1'b0);
    step(5'b10001, 1'b0);
    chk_int("t6_next_id", int'(gnt_id), 4);

    // Random traffic: slowly toggling requests with rare resets
    do_reset();
    rq = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 23) == 0) rq = rq ^ (N'(1) << b);
      rs = ($urandom_range(0, 499) == 0);
      step(rq, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
